unit_cmd_dispatcher: RTL and testbench

- Parametrised successor to the fixed 4-unit control path. Accepts control packets (unit_id, op_code, comp_type) over a valid/ready handshake and routes them to NUM_UNITS processing units.
- Runs one IDLE/FETCH/COMPUTE/WRITEBACK tracker per unit. Adds broadcast to all units, an OP_SYNC barrier, error reporting and a retire counter.
- Sits between the host command interface and the processing-unit array.

---
 rtl/unit_cmd_dispatcher_pkg.sv | 44 ++++
 rtl/unit_cmd_dispatcher_if.sv | 38 +++
 rtl/unit_cmd_dispatcher_tracker.sv | 53 +++++
 rtl/unit_cmd_dispatcher.sv | 131 +++++++++++++
 tb/tb_unit_cmd_dispatcher.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/unit_cmd_dispatcher_pkg.sv
// Shared types and constants for the command dispatcher and its per-unit trackers.
package unit_cmd_dispatcher_pkg;

  localparam int unsigned NUM_UNITS_MAX    = 15;
  localparam int unsigned DEFAULT_BCAST_ID = 15;

  typedef enum logic [1:0] {
    UNIT_IDLE      = 2'd0,
    UNIT_FETCH     = 2'd1,
    UNIT_COMPUTE   = 2'd2,
    UNIT_WRITEBACK = 2'd3
  } unit_state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_COMP  = 3'd3,
    OP_SYNC  = 3'd4
  } operation_code_t;

  typedef enum logic [2:0] {
    COMP_ADD  = 3'd0,
    COMP_SUB  = 3'd1,
    COMP_MUL  = 3'd2,
    COMP_MAC  = 3'd3,
    COMP_AND  = 3'd4,
    COMP_OR   = 3'd5,
    COMP_XOR  = 3'd6,
    COMP_PASS = 3'd7
  } computation_type_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OP   = 2'd1,
    ERR_UNIT = 2'd2,
    ERR_DONE = 2'd3
  } err_code_t;

  function automatic logic is_valid_op(logic [2:0] op);
    return op <= OP_SYNC;
  endfunction

endpackage

// File: rtl/unit_cmd_dispatcher_if.sv
// Host packet port plus processing-unit command/status bus of the dispatcher.
interface unit_cmd_dispatcher_if
  import unit_cmd_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_UNITS     = 4,
  parameter int unsigned UNIT_ID_WIDTH = 4,
  parameter int unsigned CNT_WIDTH     = 16
);
  logic                     pkt_valid;
  logic                     pkt_ready;
  logic [UNIT_ID_WIDTH-1:0] pkt_unit_id;
  logic [2:0]               pkt_op;
  logic [2:0]               pkt_comp;
  logic [NUM_UNITS-1:0]     cmd_valid;
  logic [NUM_UNITS-1:0]     cmd_ready;
  logic [3*NUM_UNITS-1:0]   cmd_op;
  logic [3*NUM_UNITS-1:0]   cmd_comp;
  logic [NUM_UNITS-1:0]     unit_done;
  logic [2*NUM_UNITS-1:0]   unit_state;
  logic                     retire_pulse;
  logic                     sync_done;
  logic                     err_valid;
  err_code_t                err_code;
  logic [CNT_WIDTH-1:0]     retire_count;

  modport master (
    output pkt_valid, pkt_unit_id, pkt_op, pkt_comp, cmd_ready, unit_done,
    input  pkt_ready, cmd_valid, cmd_op, cmd_comp, unit_state, retire_pulse, sync_done,
           err_valid, err_code, retire_count
  );

  modport slave (
    input  pkt_valid, pkt_unit_id, pkt_op, pkt_comp, cmd_ready, unit_done,
    output pkt_ready, cmd_valid, cmd_op, cmd_comp, unit_state, retire_pulse, sync_done,
           err_valid, err_code, retire_count
  );

endinterface

// File: rtl/unit_cmd_dispatcher_tracker.sv
// Per-unit IDLE/FETCH/COMPUTE/WRITEBACK tracker holding the unit's current command.
module unit_cmd_tracker
  import unit_cmd_dispatcher_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [2:0]  i_op,
  input  logic [2:0]  i_comp,
  input  logic        i_cmd_ready,
  input  logic        i_unit_done,
  output unit_state_t o_state,
  output logic        o_cmd_valid,
  output logic [2:0]  o_cmd_op,
  output logic [2:0]  o_cmd_comp,
  output logic        o_spurious
);

  unit_state_t r_state, w_state_d;
  logic [2:0]  r_op, r_comp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= UNIT_IDLE;
      r_op    <= '0;
      r_comp  <= '0;
    end else begin
      r_state <= w_state_d;
      if (i_load) begin
        r_op   <= i_op;
        r_comp <= i_comp;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      UNIT_IDLE:      if (i_load)      w_state_d = UNIT_FETCH;
      UNIT_FETCH:     if (i_cmd_ready) w_state_d = UNIT_COMPUTE;
      UNIT_COMPUTE:   if (i_unit_done) w_state_d = UNIT_WRITEBACK;
      UNIT_WRITEBACK:                  w_state_d = UNIT_IDLE;
      default:                         w_state_d = UNIT_IDLE;
    endcase
  end

  assign o_state     = r_state;
  assign o_cmd_valid = (r_state == UNIT_FETCH);
  assign o_cmd_op    = r_op;
  assign o_cmd_comp  = r_comp;
  assign o_spurious  = i_unit_done && (r_state != UNIT_COMPUTE);

endmodule

// File: rtl/unit_cmd_dispatcher.sv
// Routes host control packets through a one-entry holding register to NUM_UNITS trackers.
module unit_cmd_dispatcher
  import unit_cmd_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_UNITS     = 4,
  parameter int unsigned UNIT_ID_WIDTH = 4,
  parameter int unsigned BCAST_ID      = DEFAULT_BCAST_ID,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  unit_cmd_dispatcher_if.slave bus
);

  logic                     r_hold_full;
  logic [UNIT_ID_WIDTH-1:0] r_hold_uid;
  logic [2:0]               r_hold_op, r_hold_comp;
  logic                     r_err_valid, w_err_valid_d;
  err_code_t                r_err_code, w_err_code_d;
  logic [CNT_WIDTH-1:0]     r_retire_count, w_retire_inc;

  logic [NUM_UNITS-1:0] w_idle, w_wb, w_sel, w_load, w_spurious, w_cmd_valid;
  unit_state_t          w_state    [NUM_UNITS];
  logic [2:0]           w_cmd_op   [NUM_UNITS];
  logic [2:0]           w_cmd_comp [NUM_UNITS];

  int unsigned w_uid;
  logic w_bad_op, w_bad_unit, w_bcast, w_is_cmd, w_all_idle, w_target_idle;
  logic w_consume, w_accept, w_sync_fire;

  assign w_uid         = 32'(r_hold_uid);
  assign w_bad_op      = !is_valid_op(r_hold_op);
  assign w_bcast       = (w_uid == BCAST_ID);
  assign w_bad_unit    = (w_uid >= NUM_UNITS) && !w_bcast;
  assign w_is_cmd      = (r_hold_op == OP_LOAD) || (r_hold_op == OP_STORE) || (r_hold_op == OP_COMP);
  assign w_all_idle    = &w_idle;
  assign w_target_idle = |(w_sel & w_idle);

  // Decision uses only registered state, so pkt_ready never depends on pkt_valid.
  always_comb begin
    w_consume = 1'b0;
    if (r_hold_full) begin
      if (w_bad_op || w_bad_unit || (r_hold_op == OP_NOP)) w_consume = 1'b1;
      else if ((r_hold_op == OP_SYNC) || w_bcast)          w_consume = w_all_idle;
      else                                                 w_consume = w_target_idle;
    end
  end

  assign w_load      = (w_consume && w_is_cmd && !w_bad_unit) ? (w_bcast ? '1 : w_sel) : '0;
  assign w_sync_fire = r_hold_full && (r_hold_op == OP_SYNC) && !w_bad_unit && w_all_idle;
  assign w_accept    = bus.pkt_valid && bus.pkt_ready;

  // Packet errors win; a coincident spurious done is dropped.
  always_comb begin
    w_err_code_d = ERR_NONE;
    if (r_hold_full && w_bad_op)        w_err_code_d = ERR_OP;
    else if (r_hold_full && w_bad_unit) w_err_code_d = ERR_UNIT;
    else if (|w_spurious)               w_err_code_d = ERR_DONE;
    w_err_valid_d = (w_err_code_d != ERR_NONE);
  end

  always_comb begin
    w_retire_inc = '0;
    for (int i = 0; i < NUM_UNITS; i++) w_retire_inc += CNT_WIDTH'(w_wb[i]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_full    <= 1'b0;
      r_hold_uid     <= '0;
      r_hold_op      <= '0;
      r_hold_comp    <= '0;
      r_err_valid    <= 1'b0;
      r_err_code     <= ERR_NONE;
      r_retire_count <= '0;
    end else begin
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_uid  <= bus.pkt_unit_id;
        r_hold_op   <= bus.pkt_op;
        r_hold_comp <= bus.pkt_comp;
      end else if (w_consume) begin
        r_hold_full <= 1'b0;
      end
      r_err_valid    <= w_err_valid_d;
      r_err_code     <= w_err_code_d;
      r_retire_count <= r_retire_count + w_retire_inc;
    end
  end

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    assign w_sel[i]  = (w_uid == i);
    assign w_idle[i] = (w_state[i] == UNIT_IDLE);
    assign w_wb[i]   = (w_state[i] == UNIT_WRITEBACK);

    unit_cmd_tracker u_tracker (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_load      (w_load[i]),
      .i_op        (r_hold_op),
      .i_comp      (r_hold_comp),
      .i_cmd_ready (bus.cmd_ready[i]),
      .i_unit_done (bus.unit_done[i]),
      .o_state     (w_state[i]),
      .o_cmd_valid (w_cmd_valid[i]),
      .o_cmd_op    (w_cmd_op[i]),
      .o_cmd_comp  (w_cmd_comp[i]),
      .o_spurious  (w_spurious[i])
    );
  end

  always_comb begin
    bus.cmd_op     = '0;
    bus.cmd_comp   = '0;
    bus.unit_state = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      bus.cmd_op[3*i +: 3]     = w_cmd_op[i];
      bus.cmd_comp[3*i +: 3]   = w_cmd_comp[i];
      bus.unit_state[2*i +: 2] = w_state[i];
    end
  end

  assign bus.pkt_ready    = !r_hold_full || w_consume;
  assign bus.cmd_valid    = w_cmd_valid;
  assign bus.retire_pulse = |w_wb;
  assign bus.sync_done    = w_sync_fire;
  assign bus.err_valid    = r_err_valid;
  assign bus.err_code     = r_err_code;
  assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_unit_cmd_dispatcher.sv
// Directed self-checking bench for unit_cmd_dispatcher with four units.
module tb_unit_cmd_dispatcher;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  unit_cmd_dispatcher_if #(.NUM_UNITS(4), .UNIT_ID_WIDTH(4), .CNT_WIDTH(16)) bus ();

  unit_cmd_dispatcher #(
    .NUM_UNITS     (4),
    .UNIT_ID_WIDTH (4),
    .BCAST_ID      (15),
    .CNT_WIDTH     (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a packet and returns 1 ns after the edge that accepted it.
  task automatic send(input logic [3:0] uid, input logic [2:0] op, input logic [2:0] comp);
    int n = 0;
    bus.pkt_valid   = 1'b1;
    bus.pkt_unit_id = uid;
    bus.pkt_op      = op;
    bus.pkt_comp    = comp;
    while (bus.pkt_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: pkt_ready=%b want 1", bus.pkt_ready);
    end
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pkt_valid = 1'b0; bus.pkt_unit_id = '0; bus.pkt_op = '0; bus.pkt_comp = '0;
    bus.cmd_ready = '0; bus.unit_done = '0;
    #12;
    checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.pkt_ready); end
    checks++; if (bus.cmd_valid !== 4'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
    checks++; if (bus.unit_state !== 8'h00) begin errors++; $display("FAIL reset_state: got %h want 00", bus.unit_state); end
    checks++; if (bus.retire_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.retire_count); end
    checks++; if ({bus.err_valid, bus.sync_done, bus.retire_pulse} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b want 000", {bus.err_valid, bus.sync_done, bus.retire_pulse}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    send(4'd2, 3'd3, 3'd5);
    checks++; if (bus.unit_state[5:4] !== 2'd0) begin errors++; $display("FAIL single_held: got %0d want 0", bus.unit_state[5:4]); end
    bus.cmd_ready = 4'b0100;
    tick();
    checks++; if (bus.unit_state[5:4] !== 2'd1) begin errors++; $display("FAIL single_fetch: got %0d want 1", bus.unit_state[5:4]); end
    checks++; if (bus.cmd_valid !== 4'b0100) begin errors++; $display("FAIL single_cmd_valid: got %b want 0100", bus.cmd_valid); end
    checks++; if (bus.cmd_op[8:6] !== 3'd3 || bus.cmd_comp[8:6] !== 3'd5) begin
      errors++; $display("FAIL single_cmd: got op=%0d comp=%0d want 3 5", bus.cmd_op[8:6], bus.cmd_comp[8:6]); end
    tick();
    bus.cmd_ready = 4'b0000;
    checks++; if (bus.unit_state[5:4] !== 2'd2 || bus.cmd_valid !== 4'b0) begin
      errors++; $display("FAIL single_compute: got st=%0d cv=%b want 2 0000", bus.unit_state[5:4], bus.cmd_valid); end
    tick(); tick();
    bus.unit_done = 4'b0100;
    tick();
    bus.unit_done = 4'b0000;
    checks++; if (bus.unit_state[5:4] !== 2'd3 || bus.retire_pulse !== 1'b1) begin
      errors++; $display("FAIL single_wb: got st=%0d rp=%b want 3 1", bus.unit_state[5:4], bus.retire_pulse); end
    checks++; if (bus.err_valid !== 1'b0) begin errors++; $display("FAIL single_no_err: got %b want 0", bus.err_valid); end
    tick();
    checks++; if (bus.unit_state !== 8'h00 || bus.retire_pulse !== 1'b0) begin
      errors++; $display("FAIL single_idle: got st=%h rp=%b want 00 0", bus.unit_state, bus.retire_pulse); end
    checks++; if (bus.retire_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.retire_count); end
    checks++; if (bus.cmd_op[8:6] !== 3'd3) begin errors++; $display("FAIL single_op_stable: got %0d want 3", bus.cmd_op[8:6]); end
  endtask

  task automatic test_broadcast();
    bus.cmd_ready = 4'b0010;
    send(4'd1, 3'd3, 3'd0);
    tick(); tick();
    checks++; if (bus.unit_state[3:2] !== 2'd2) begin errors++; $display("FAIL bc_u1_busy: got %0d want 2", bus.unit_state[3:2]); end
    send(4'd15, 3'd1, 3'd2);
    tick(); tick();
    checks++; if (bus.cmd_valid !== 4'b0 || bus.pkt_ready !== 1'b0) begin
      errors++; $display("FAIL bc_held: got cv=%b rdy=%b want 0000 0", bus.cmd_valid, bus.pkt_ready); end
    bus.unit_done = 4'b0010;
    tick();
    bus.unit_done = 4'b0000;
    checks++; if (bus.unit_state[3:2] !== 2'd3 || bus.cmd_valid !== 4'b0) begin
      errors++; $display("FAIL bc_wb_held: got st=%0d cv=%b want 3 0000", bus.unit_state[3:2], bus.cmd_valid); end
    tick();
    checks++; if (bus.retire_count !== 16'd2 || bus.cmd_valid !== 4'b0) begin
      errors++; $display("FAIL bc_u1_retired: got cnt=%0d cv=%b want 2 0000", bus.retire_count, bus.cmd_valid); end
    bus.cmd_ready = 4'b1111;
    tick();
    checks++; if (bus.cmd_valid !== 4'b1111) begin errors++; $display("FAIL bc_all_valid: got %b want 1111", bus.cmd_valid); end
    checks++; if (bus.cmd_op !== 12'h249 || bus.cmd_comp !== 12'h492) begin
      errors++; $display("FAIL bc_cmd: got op=%h comp=%h want 249 492", bus.cmd_op, bus.cmd_comp); end
    checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL bc_ready_back: got %b want 1", bus.pkt_ready); end
    tick();
    checks++; if (bus.unit_state !== 8'hAA) begin errors++; $display("FAIL bc_compute: got %h want aa", bus.unit_state); end
    bus.unit_done = 4'b1111;
    tick();
    bus.unit_done = 4'b0000;
    checks++; if (bus.unit_state !== 8'hFF || bus.retire_count !== 16'd2) begin
      errors++; $display("FAIL bc_wb: got st=%h cnt=%0d want ff 2", bus.unit_state, bus.retire_count); end
    tick();
    checks++; if (bus.retire_count !== 16'd6) begin errors++; $display("FAIL bc_count: got %0d want 6", bus.retire_count); end
  endtask

  task automatic test_sync();
    bus.cmd_ready = 4'b1111;
    send(4'd0, 3'd3, 3'd1);
    send(4'd3, 3'd3, 3'd1);
    send(4'd0, 3'd4, 3'd0);
    bus.pkt_valid = 1'b1; bus.pkt_unit_id = 4'd1; bus.pkt_op = 3'd1; bus.pkt_comp = 3'd0;
    checks++; if (bus.pkt_ready !== 1'b0 || bus.sync_done !== 1'b0) begin
      errors++; $display("FAIL sync_wait: got rdy=%b sd=%b want 0 0", bus.pkt_ready, bus.sync_done); end
    tick();
    checks++; if (bus.unit_state !== 8'h82 || bus.sync_done !== 1'b0) begin
      errors++; $display("FAIL sync_busy: got st=%h sd=%b want 82 0", bus.unit_state, bus.sync_done); end
    bus.unit_done = 4'b0001;
    tick();
    bus.unit_done = 4'b1000;
    tick();
    bus.unit_done = 4'b0000;
    checks++; if (bus.unit_state !== 8'hC0 || bus.sync_done !== 1'b0) begin
      errors++; $display("FAIL sync_u3_wb: got st=%h sd=%b want c0 0", bus.unit_state, bus.sync_done); end
    tick();
    checks++; if (bus.sync_done !== 1'b1 || bus.pkt_ready !== 1'b1) begin
      errors++; $display("FAIL sync_fire: got sd=%b rdy=%b want 1 1", bus.sync_done, bus.pkt_ready); end
    checks++; if (bus.retire_count !== 16'd8) begin errors++; $display("FAIL sync_count: got %0d want 8", bus.retire_count); end
    tick();
    bus.pkt_valid = 1'b0;
    checks++; if (bus.sync_done !== 1'b0 || bus.unit_state !== 8'h00) begin
      errors++; $display("FAIL sync_after: got sd=%b st=%h want 0 00", bus.sync_done, bus.unit_state); end
    tick();
    checks++; if (bus.unit_state !== 8'h04 || bus.cmd_valid !== 4'b0010) begin
      errors++; $display("FAIL sync_next: got st=%h cv=%b want 04 0010", bus.unit_state, bus.cmd_valid); end
    tick();
    bus.unit_done = 4'b0010;
    tick();
    bus.unit_done = 4'b0000;
    tick();
    checks++; if (bus.retire_count !== 16'd9) begin errors++; $display("FAIL sync_count2: got %0d want 9", bus.retire_count); end
  endtask

  task automatic test_errors();
    send(4'd0, 3'd7, 3'd0);
    tick();
    checks++; if (bus.err_valid !== 1'b1 || bus.err_code !== 2'b01) begin
      errors++; $display("FAIL err_op: got v=%b c=%b want 1 01", bus.err_valid, bus.err_code); end
    checks++; if (bus.cmd_valid !== 4'b0) begin errors++; $display("FAIL err_op_nocmd: got %b want 0000", bus.cmd_valid); end
    tick();
    checks++; if (bus.err_valid !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b want 0", bus.err_valid); end
    send(4'd9, 3'd1, 3'd0);
    tick();
    checks++; if (bus.err_valid !== 1'b1 || bus.err_code !== 2'b10) begin
      errors++; $display("FAIL err_unit: got v=%b c=%b want 1 10", bus.err_valid, bus.err_code); end
    checks++; if (bus.cmd_valid !== 4'b0 || bus.unit_state !== 8'h00) begin
      errors++; $display("FAIL err_unit_nocmd: got cv=%b st=%h want 0000 00", bus.cmd_valid, bus.unit_state); end
    send(4'd9, 3'd7, 3'd0);
    tick();
    checks++; if (bus.err_code !== 2'b01) begin errors++; $display("FAIL err_prio: got %b want 01", bus.err_code); end
    tick();
    checks++; if (bus.retire_count !== 16'd9) begin errors++; $display("FAIL err_count: got %0d want 9", bus.retire_count); end
  endtask

  task automatic test_spurious();
    bus.unit_done = 4'b0001;
    tick();
    bus.unit_done = 4'b0000;
    checks++; if (bus.err_valid !== 1'b1 || bus.err_code !== 2'b11) begin
      errors++; $display("FAIL spur_done: got v=%b c=%b want 1 11", bus.err_valid, bus.err_code); end
    checks++; if (bus.unit_state !== 8'h00) begin errors++; $display("FAIL spur_state: got %h want 00", bus.unit_state); end
    tick();
    send(4'd0, 3'd6, 3'd0);
    bus.unit_done = 4'b0001;
    tick();
    bus.unit_done = 4'b0000;
    checks++; if (bus.err_valid !== 1'b1 || bus.err_code !== 2'b01) begin
      errors++; $display("FAIL spur_vs_op: got v=%b c=%b want 1 01", bus.err_valid, bus.err_code); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.cmd_ready = 4'b1111;
    bus.pkt_valid = 1'b1; bus.pkt_op = 3'd3; bus.pkt_comp = 3'd3;
    for (int k = 0; k < 4; k++) begin
      bus.pkt_unit_id = 4'(k);
      checks++; if (bus.pkt_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, bus.pkt_ready); end
      tick();
    end
    bus.pkt_valid = 1'b0;
    checks++; if (bus.unit_state !== 8'h1A || bus.cmd_valid !== 4'b0100) begin
      errors++; $display("FAIL b2b_state: got st=%h cv=%b want 1a 0100", bus.unit_state, bus.cmd_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.cmd_valid !== 4'b0 || bus.unit_state !== 8'h00) begin
      errors++; $display("FAIL rst_async: got cv=%b st=%h want 0000 00", bus.cmd_valid, bus.unit_state); end
    checks++; if (bus.retire_count !== 16'd0 || bus.pkt_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async_cnt: got cnt=%0d rdy=%b want 0 1", bus.retire_count, bus.pkt_ready); end
    #2 rst_n = 1'b1;
    tick(); tick();
    checks++; if (bus.unit_state !== 8'h00 || bus.retire_count !== 16'd0 || bus.cmd_valid !== 4'b0) begin
      errors++; $display("FAIL rst_after: got st=%h cnt=%0d cv=%b want 00 0 0000",
                         bus.unit_state, bus.retire_count, bus.cmd_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_broadcast();
    test_sync();
    test_errors();
    test_spurious();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
